attn_col_softmax: RTL

Parametrised column-wise softmax-approximation stage for the attention datapath. It receives raw PE accumulator results one element at a time in column-major order and quantizes each to DATA_W bits with round and saturate. It subtracts the column minimum and either squares the difference and requantizes (mode 0) or passes it through linearly (mode 1), then streams the normalized scores out to the score×value pass. Compared with the fixed 8×8 inline logic it replaces, it adds an N-generic size, valid/ready handshakes, a linear mode and per-element saturation flags.

---
 rtl/attn_col_softmax.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/attn_col_softmax.sv
// Column-wise softmax-approximation stage for the attention datapath.
// Raw accumulator results arrive one element at a time in column-major order.
// Each column is quantized into a local buffer and its minimum is tracked.
// The column is then replayed with the minimum subtracted. In mode 0 the
// difference is squared and requantized; in mode 1 it is passed through.
module attn_col_softmax #(
  parameter int N      = 8,
  parameter int ACC_W  = 36,
  parameter int DATA_W = 16,
  parameter int FRAC   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ACC_W-1:0]  in_acc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat,
  output logic              out_last_col,
  output logic              out_last
);

  localparam int RW   = (N > 1) ? $clog2(N) : 1;
  localparam int SQ_W = 2 * DATA_W;
  // Common width for both quantizers; narrower sources are zero-extended.
  localparam int QW   = (ACC_W > SQ_W) ? ACC_W : SQ_W;

  localparam logic [RW-1:0] ZERO_R = RW'(0);
  localparam logic [RW-1:0] ONE_R  = RW'(1);
  localparam logic [RW-1:0] LAST_R = RW'(N - 1);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // Round-half-up quantizer with saturation. Returns {sat, value}.
  // Saturates when bits above the kept field are set, or when the kept
  // field plus round bit are all ones (rounding would overflow).
  function automatic logic [DATA_W:0] quant_f(input logic [QW-1:0] v);
    logic            hi_nz;
    logic            rnd_ones;
    logic [DATA_W:0] res;
    hi_nz    = |v[QW-1:FRAC+DATA_W];
    rnd_ones = &v[FRAC+DATA_W-1:FRAC-1];
    if (hi_nz || rnd_ones) begin
      res = {1'b1, {DATA_W{1'b1}}};
    end else begin
      res = {1'b0, v[FRAC+DATA_W-1:FRAC] + {{(DATA_W-1){1'b0}}, v[FRAC-1]}};
    end
    return res;
  endfunction

  state_t            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [RW-1:0]     col_q, col_d;
  logic [DATA_W-1:0] min_q, min_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] buf_q [N];
  logic [DATA_W-1:0] buf_d [N];
  logic [N-1:0]      sat_q, sat_d;

  logic              acc_fire_s;
  logic              out_fire_s;
  logic [DATA_W:0]   q_in_s;
  logic [DATA_W-1:0] diff_s;
  logic [SQ_W-1:0]   sq_s;
  logic [DATA_W:0]   q_sq_s;
  logic [DATA_W-1:0] data_s;
  logic              sat_s;

  assign acc_fire_s = en && (state_q == ST_LOAD) && in_valid;
  assign out_fire_s = en && (state_q == ST_EMIT) && out_ready;

  assign q_in_s = quant_f(QW'(in_acc));
  // Buffered values are never below the column minimum, so this cannot wrap.
  assign diff_s = buf_q[row_q] - min_q;
  assign sq_s   = {{DATA_W{1'b0}}, diff_s} * {{DATA_W{1'b0}}, diff_s};
  assign q_sq_s = quant_f(QW'(sq_s));

  // Select the emitted score and its saturation flag for the current row.
  always_comb begin
    data_s = diff_s;
    sat_s  = sat_q[row_q];
    if (mode_q == 1'b0) begin
      data_s = q_sq_s[DATA_W-1:0];
      sat_s  = sat_q[row_q] | q_sq_s[DATA_W];
    end else begin
      data_s = diff_s;
      sat_s  = sat_q[row_q];
    end
  end

  // Next-state logic: column load, minimum tracking, emit sequencing.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    min_d   = min_q;
    mode_d  = mode_q;
    buf_d   = buf_q;
    sat_d   = sat_q;
    case (state_q)
      ST_LOAD: begin
        if (acc_fire_s) begin
          buf_d[row_q] = q_in_s[DATA_W-1:0];
          sat_d[row_q] = q_in_s[DATA_W];
          if (row_q == ZERO_R) begin
            min_d = q_in_s[DATA_W-1:0];
          end else if (q_in_s[DATA_W-1:0] < min_q) begin
            min_d = q_in_s[DATA_W-1:0];
          end else begin
            min_d = min_q;
          end
          // Mode is captured only on the first element of a matrix.
          if ((row_q == ZERO_R) && (col_q == ZERO_R)) begin
            mode_d = mode;
          end else begin
            mode_d = mode_q;
          end
          if (row_q == LAST_R) begin
            row_d   = ZERO_R;
            state_d = ST_EMIT;
          end else begin
            row_d   = row_q + ONE_R;
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_EMIT: begin
        if (out_fire_s) begin
          if (row_q == LAST_R) begin
            row_d   = ZERO_R;
            state_d = ST_LOAD;
            if (col_q == LAST_R) begin
              col_d = ZERO_R;
            end else begin
              col_d = col_q + ONE_R;
            end
          end else begin
            row_d   = row_q + ONE_R;
            state_d = ST_EMIT;
          end
        end else begin
          state_d = ST_EMIT;
        end
      end
      default: begin
        state_d = ST_LOAD;
        row_d   = ZERO_R;
      end
    endcase
  end

  // State registers with synchronous active-low reset; en low holds via _d.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      row_q   <= ZERO_R;
      col_q   <= ZERO_R;
      min_q   <= {DATA_W{1'b0}};
      mode_q  <= 1'b0;
      sat_q   <= {N{1'b0}};
      for (int i = 0; i < N; i++) begin
        buf_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      min_q   <= min_d;
      mode_q  <= mode_d;
      sat_q   <= sat_d;
      for (int i = 0; i < N; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  // Output drive; everything reads zero while reset is asserted.
  always_comb begin
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_data     = {DATA_W{1'b0}};
    out_sat      = 1'b0;
    out_last_col = 1'b0;
    out_last     = 1'b0;
    if (rst_n) begin
      in_ready     = en && (state_q == ST_LOAD);
      out_valid    = en && (state_q == ST_EMIT);
      out_data     = data_s;
      out_sat      = sat_s;
      out_last_col = (state_q == ST_EMIT) && (row_q == LAST_R);
      out_last     = (state_q == ST_EMIT) && (row_q == LAST_R) && (col_q == LAST_R);
    end else begin
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      out_data     = {DATA_W{1'b0}};
      out_sat      = 1'b0;
      out_last_col = 1'b0;
      out_last     = 1'b0;
    end
  end

endmodule
